mm_result_buffer: RTL

Result buffer directly downstream of the 8x8 matrix-multiply MAC controller. It captures the 19-bit signed dot products the MAC controller emits, one per `wr_en` pulse, into a 64-entry store. Once all 64 results are in, it streams them out on a valid/ready interface in row-major order, optionally transposing the arrival order. It also reports completion and sticky error flags.

---
 rtl/mm_result_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/mm_result_buffer.sv
// mm_result_buffer: capture DIM*DIM signed MAC results, then stream them out (optionally transposed) over valid/ready.
// Ports: clk/reset (sync, active-high); wr_en/wr_data fill side; restart starts a new fill;
// rd_valid/rd_ready/rd_data/rd_index drain side; count/full/drain_done status; err_overflow/err_short sticky errors.
module mm_result_buffer #(
  parameter int DATA_W = 19,
  parameter int DIM = 8,
  parameter int TRANSPOSE = 1,
  localparam int DEPTH = DIM * DIM,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     restart,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic signed [DATA_W-1:0] rd_data,
  output logic [AW-1:0]            rd_index,
  output logic [AW:0]              count,
  output logic                     full,
  output logic                     drain_done,
  output logic                     err_overflow,
  output logic                     err_short
);
  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;
  localparam logic [AW:0] LAST_WR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_RD = AW'(DEPTH - 1);
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic restart_q;
  logic [AW:0] ld_idx;
  logic [AW-1:0] ld_pos, src;
  logic restart_edge, do_wr, load, xfer;
  // Arrival is column-major, so the transposed address turns readout into row-major order.
  always_comb begin
    ld_pos = ld_idx[AW-1:0];
    src = TRANSPOSE != 0 ? AW'((int'(ld_pos) % DIM) * DIM + int'(ld_pos) / DIM) : ld_pos;
    restart_edge = restart && !restart_q;
    do_wr = state == FILL && wr_en && !restart_edge;
    xfer = rd_valid && rd_ready;
    load = state == DRAIN && ld_idx < DEPTH_C && (!rd_valid || rd_ready);
  end
  always_ff @(posedge clk)
    if (do_wr) mem[count[AW-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      restart_q <= 1'b0;
      ld_idx <= '0;
      count <= '0;
      full <= 1'b0;
      drain_done <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_index <= '0;
      err_overflow <= 1'b0;
      err_short <= 1'b0;
    end else begin
      restart_q <= restart;
      if (wr_en && state != FILL) err_overflow <= 1'b1;
      if (restart_edge) begin
        if (state == DRAIN) err_short <= 1'b1;
        state <= FILL;
        ld_idx <= '0;
        count <= '0;
        full <= 1'b0;
        drain_done <= 1'b0;
        rd_valid <= 1'b0;
      end else if (do_wr) begin
        count <= count + 1'b1;
        if (count == LAST_WR) begin
          full <= 1'b1;
          state <= DRAIN;
        end
      end else if (state == DRAIN) begin
        if (load) begin
          rd_valid <= 1'b1;
          rd_data <= mem[src];
          rd_index <= ld_pos;
          ld_idx <= ld_idx + 1'b1;
        end else if (xfer) begin
          rd_valid <= 1'b0;
          if (rd_index == LAST_RD) begin
            drain_done <= 1'b1;
            state <= DONE;
          end
        end
      end
    end
  end
endmodule
